// File: rtl/fc_ctrl_pkg.sv
// Shared control definitions for the fully-connected layer sequencer.
package fc_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_DRAIN
  } fc_state_e;

  // Result width of a neuron: full product width plus growth of an IN-term sum.
  function automatic int unsigned owidth_default(input int unsigned width,
                                                 input int unsigned in_len);
    return width * 2 + $clog2(in_len);
  endfunction

endpackage

// File: rtl/fc_result_buf.sv
// Capture register for all neuron results and the one-per-cycle drain port.
module fc_result_buf #(
  parameter int unsigned OUT    = 54,
  parameter int unsigned OWIDTH = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    capture,
  input  logic [OWIDTH-1:0]       z_all [0:OUT-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OWIDTH-1:0]       out_data,
  output logic [$clog2(OUT)-1:0]  out_idx,
  output logic                    drained
);

  localparam logic [$clog2(OUT)-1:0] LAST_OUT = ($clog2(OUT))'(OUT - 1);

  logic [OWIDTH-1:0]      res [0:OUT-1];
  logic [$clog2(OUT)-1:0] rd_idx;
  logic                   valid_q;
  logic                   fire;

  assign fire      = valid_q & out_ready;
  assign drained   = fire & (rd_idx == LAST_OUT) & ~flush;
  assign out_valid = valid_q;
  assign out_idx   = rd_idx;
  assign out_data  = valid_q ? res[rd_idx] : '0;

  // Snapshot the whole array on capture, then walk rd_idx on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < OUT; i++) res[i] <= '0;
      rd_idx  <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      rd_idx  <= '0;
      valid_q <= 1'b0;
    end else if (capture) begin
      for (int unsigned i = 0; i < OUT; i++) res[i] <= z_all[i];
      rd_idx  <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      if (rd_idx == LAST_OUT) begin
        rd_idx  <= '0;
        valid_q <= 1'b0;
      end else begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Sequencer for one FC layer: load input vector, settle the neuron array, drain results.
module fc_layer_seq
  import fc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IN     = 400,
  parameter int unsigned OUT    = 54,
  parameter int unsigned OWIDTH = owidth_default(WIDTH, IN),
  parameter int unsigned SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic [WIDTH-1:0]        x_vec [0:IN-1],
  input  logic [OWIDTH-1:0]       z_all [0:OUT-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OWIDTH-1:0]       out_data,
  output logic [$clog2(OUT)-1:0]  out_idx,
  output logic                    done,
  output logic                    busy
);

  localparam int unsigned IW = $clog2(IN);
  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam logic [IW-1:0] LAST_IN  = IW'(IN - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

  fc_state_e         state, state_nx;
  logic [WIDTH-1:0]  xbuf [0:IN-1];
  logic [IW-1:0]     wr_idx;
  logic [CW-1:0]     cnt;
  logic              in_fire;
  logic              last_in;
  logic              capture;
  logic              drained;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_SETTLE) | (state == S_DRAIN);
  assign in_fire  = in_valid & in_ready & ~flush;
  assign last_in  = in_fire & (wr_idx == LAST_IN);
  assign capture  = (state == S_SETTLE) & (cnt == '0) & ~flush;
  assign done     = drained;
  assign x_vec    = xbuf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   state_nx = S_LOAD;
      S_LOAD:   if (last_in) state_nx = S_SETTLE;
      S_SETTLE: if (cnt == '0) state_nx = S_DRAIN;
      S_DRAIN:  if (drained) state_nx = S_LOAD;
      default:  state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // Input buffer fill, write index and settle countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < IN; i++) xbuf[i] <= '0;
      wr_idx <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_idx <= '0;
      cnt    <= '0;
    end else begin
      if (in_fire) begin
        xbuf[wr_idx] <= in_data;
        wr_idx       <= last_in ? '0 : wr_idx + 1'b1;
      end
      if (last_in) cnt <= CNT_INIT;
      else if (state == S_SETTLE && cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  fc_result_buf #(
    .OUT    (OUT),
    .OWIDTH (OWIDTH)
  ) u_res (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .capture   (capture),
    .z_all     (z_all),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .drained   (drained)
  );

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq: default instance plus SETTLE=1 and SETTLE=4 variants.
module tb_fc_layer_seq;

  localparam int W   = 8;
  localparam int IN  = 400;
  localparam int OUT = 54;
  localparam int OW  = 25;
  localparam int XW  = 6;

  logic clk, rst_n, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic [W-1:0]  x0 [0:IN-1], x1 [0:IN-1], x4 [0:IN-1];
  logic [OW-1:0] z0 [0:OUT-1], z1 [0:OUT-1], z4 [0:OUT-1];
  logic in_ready0, in_ready1, in_ready4;
  logic out_valid0, out_valid1, out_valid4;
  logic [OW-1:0] out_data0, out_data1, out_data4;
  logic [XW-1:0] out_idx0, out_idx1, out_idx4;
  logic done0, done1, done4, busy0, busy1, busy4;

  int zoff0, zoff1, zoff4;
  int a0, a1, a4;
  int n_asrt = 0;
  int n_fail = 0;

  fc_layer_seq u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .x_vec(x0), .z_all(z0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_idx(out_idx0), .done(done0), .busy(busy0)
  );

  fc_layer_seq #(.SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .x_vec(x1), .z_all(z1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_idx(out_idx1), .done(done1), .busy(busy1)
  );

  fc_layer_seq #(.SETTLE(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .x_vec(x4), .z_all(z4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_idx(out_idx4), .done(done4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model neuron array: z[j] = (j+1) * sum of 7 consecutive activations, plus a bench offset.
  always_comb begin
    a0 = 0;
    for (int j = 0; j < OUT; j++) begin
      a0 = 0;
      for (int k = 0; k < 7; k++) a0 += int'(x0[j*7+k]);
      z0[j] = OW'(a0 * (j + 1) + zoff0);
    end
  end
  always_comb begin
    a1 = 0;
    for (int j = 0; j < OUT; j++) begin
      a1 = 0;
      for (int k = 0; k < 7; k++) a1 += int'(x1[j*7+k]);
      z1[j] = OW'(a1 * (j + 1) + zoff1);
    end
  end
  always_comb begin
    a4 = 0;
    for (int j = 0; j < OUT; j++) begin
      a4 = 0;
      for (int k = 0; k < 7; k++) a4 += int'(x4[j*7+k]);
      z4[j] = OW'(a4 * (j + 1) + zoff4);
    end
  end

  // Expected neuron result when the streamed vector was x[i] = (i+base) mod 128.
  function automatic logic [OW-1:0] exp_z(input int j, input int base);
    int s;
    s = 0;
    for (int k = 0; k < 7; k++) s += (j * 7 + k + base) % 128;
    return OW'(s * (j + 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream stop_at elements of the pattern; returns 1ns after the last handshake edge.
  task automatic load_vec(input int base, input int idle_pct, input int stop_at);
    int n, guard;
    bit fire;
    n = 0;
    guard = 0;
    while (n < stop_at && guard < 4000) begin
      in_valid = ($urandom_range(99) >= idle_pct);
      in_data  = W'((n + base) % 128);
      #3;
      fire = in_valid && in_ready0;
      tick();
      guard++;
      if (fire) n++;
    end
    in_valid = 1'b0;
    if (n < stop_at) begin
      n_asrt++; n_fail++;
      $display("FAIL load_timeout: accepted %0d, required %0d", n, stop_at);
    end
  endtask

  // Drain stop_at results from the default instance with a 4-cycle ready pattern.
  task automatic drain_vec(input int base, input int stop_at, input logic [3:0] pat,
                           input bit junk, output int got, output int dones);
    int c, guard;
    bit held;
    logic [OW-1:0] hd;
    logic [XW-1:0] hi;
    got = 0; dones = 0; c = 0; guard = 0; held = 0; hd = '0; hi = '0;
    while (got < stop_at && guard < 2000) begin
      out_ready = pat[c % 4];
      c++;
      if (junk) begin in_valid = 1'b1; in_data = 8'h55; end
      #3;
      if (out_valid0) begin
        if (held) begin
          n_asrt++;
          if (out_data0 !== hd || out_idx0 !== hi) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d/%0d, required %0d/%0d", out_data0, out_idx0, hd, hi);
          end
        end
        if (out_ready) begin
          n_asrt++;
          if (out_idx0 !== XW'(got)) begin
            n_fail++; $display("FAIL out_idx: got %0d, required %0d", out_idx0, got);
          end
          n_asrt++;
          if (out_data0 !== exp_z(got, base)) begin
            n_fail++; $display("FAIL out_data[%0d]: got %0d, required %0d", got, out_data0, exp_z(got, base));
          end
          n_asrt++;
          if (done0 !== (got == OUT - 1)) begin
            n_fail++; $display("FAIL done_timing[%0d]: got %0b, required %0b", got, done0, got == OUT - 1);
          end
          if (done0) dones++;
          got++;
          held = 0;
        end else begin
          held = 1; hd = out_data0; hi = out_idx0;
        end
      end
      tick();
      guard++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (got < stop_at) begin
      n_asrt++; n_fail++;
      $display("FAIL drain_timeout: got %0d results, required %0d", got, stop_at);
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    zoff0 = 0; zoff1 = 0; zoff4 = 0;
    #12;
    n_asrt++;
    if ({in_ready0, out_valid0, done0, busy0} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 0000", {in_ready0, out_valid0, done0, busy0});
    end
    n_asrt++;
    if (out_data0 !== '0 || out_idx0 !== '0) begin
      n_fail++; $display("FAIL reset_out: got %0d/%0d, required 0/0", out_data0, out_idx0);
    end
    ok = 1;
    for (int i = 0; i < IN; i++) if (x0[i] !== '0) ok = 0;
    n_asrt++;
    if (!ok) begin n_fail++; $display("FAIL reset_xvec: got nonzero, required all 0"); end
    tick();
    rst_n = 1'b1;
    #3;
    n_asrt++;
    if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL ready_idle: got %b, required 0", in_ready0); end
    tick();
    n_asrt++;
    if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL ready_first: got %b, required 1", in_ready0); end
  endtask

  // Base vector on all three instances; checks capture edge and out_valid latency per SETTLE.
  task automatic test_settle_variants();
    int dones;
    bit ok;
    zoff0 = 777; zoff1 = 777; zoff4 = 777;
    load_vec(0, 0, IN);
    n_asrt++;
    if (x0[IN-1] !== W'((IN - 1) % 128)) begin
      n_fail++; $display("FAIL xvec_complete: got %0d, required %0d", x0[IN-1], (IN - 1) % 128);
    end
    for (int t = 0; t < 6; t++) begin
      zoff1 = (t == 0) ? 0 : 100 + t;
      zoff0 = (t == 1) ? 0 : 100 + t;
      zoff4 = (t == 3) ? 0 : 100 + t;
      in_valid = 1'b1; in_data = 8'h55;
      #3;
      n_asrt++;
      if (out_valid1 !== (t >= 1)) begin n_fail++; $display("FAIL lat_s1[t=%0d]: got %b, required %b", t, out_valid1, t >= 1); end
      n_asrt++;
      if (out_valid0 !== (t >= 2)) begin n_fail++; $display("FAIL lat_s2[t=%0d]: got %b, required %b", t, out_valid0, t >= 2); end
      n_asrt++;
      if (out_valid4 !== (t >= 4)) begin n_fail++; $display("FAIL lat_s4[t=%0d]: got %b, required %b", t, out_valid4, t >= 4); end
      n_asrt++;
      if (in_ready0 !== 1'b0 || busy0 !== 1'b1) begin
        n_fail++; $display("FAIL settle_ctrl[t=%0d]: ready/busy %b%b, required 01", t, in_ready0, busy0);
      end
      tick();
    end
    dones = 0;
    out_ready = 1'b1;
    for (int k = 0; k < OUT; k++) begin
      #3;
      n_asrt++;
      if (!out_valid0 || out_idx0 !== XW'(k) || out_data0 !== exp_z(k, 0)) begin
        n_fail++; $display("FAIL s2_data[%0d]: got %0d idx %0d, required %0d", k, out_data0, out_idx0, exp_z(k, 0));
      end
      n_asrt++;
      if (!out_valid1 || out_idx1 !== XW'(k) || out_data1 !== exp_z(k, 0)) begin
        n_fail++; $display("FAIL s1_data[%0d]: got %0d idx %0d, required %0d", k, out_data1, out_idx1, exp_z(k, 0));
      end
      n_asrt++;
      if (!out_valid4 || out_idx4 !== XW'(k) || out_data4 !== exp_z(k, 0)) begin
        n_fail++; $display("FAIL s4_data[%0d]: got %0d idx %0d, required %0d", k, out_data4, out_idx4, exp_z(k, 0));
      end
      if (done0) dones++;
      tick();
    end
    out_ready = 1'b0; in_valid = 1'b0;
    zoff0 = 0; zoff1 = 0; zoff4 = 0;
    n_asrt++;
    if (dones != 1) begin n_fail++; $display("FAIL done_once: got %0d pulses, required 1", dones); end
    ok = 1;
    for (int i = 0; i < IN; i++) if (x0[i] !== W'(i % 128) || x4[i] !== W'(i % 128)) ok = 0;
    n_asrt++;
    if (!ok) begin n_fail++; $display("FAIL xvec_hold: got modified buffer, required pattern base 0"); end
  endtask

  task automatic test_backpressure();
    int got, dones;
    load_vec(3, 0, IN);
    drain_vec(3, OUT, 4'b1001, 1'b0, got, dones);
    n_asrt++;
    if (got != OUT) begin n_fail++; $display("FAIL bp_count: got %0d, required %0d", got, OUT); end
    n_asrt++;
    if (dones != 1) begin n_fail++; $display("FAIL bp_done: got %0d, required 1", dones); end
  endtask

  task automatic test_gaps();
    int got, dones;
    bit ok;
    load_vec(0, 30, IN);
    drain_vec(0, OUT, 4'b1111, 1'b1, got, dones);
    n_asrt++;
    if (dones != 1) begin n_fail++; $display("FAIL gaps_done: got %0d, required 1", dones); end
    ok = 1;
    for (int i = 0; i < IN; i++) if (x0[i] !== W'(i % 128)) ok = 0;
    n_asrt++;
    if (!ok) begin n_fail++; $display("FAIL gaps_xvec_hold: got modified buffer, required pattern base 0"); end
  endtask

  task automatic test_flush_load();
    int got, dones;
    load_vec(7, 0, 200);
    in_valid = 1'b1; in_data = 8'hAA; flush = 1'b1;
    #3;
    n_asrt++;
    if (done0 !== 1'b0) begin n_fail++; $display("FAIL fl_done: got %b, required 0", done0); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_asrt++;
    if ({in_ready0, busy0, out_valid0} !== 3'b000) begin
      n_fail++; $display("FAIL fl_idle: got %b, required 000", {in_ready0, busy0, out_valid0});
    end
    tick();
    n_asrt++;
    if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL fl_reload: got %b, required 1", in_ready0); end
    load_vec(5, 0, IN);
    drain_vec(5, OUT, 4'b1111, 1'b0, got, dones);
    n_asrt++;
    if (dones != 1) begin n_fail++; $display("FAIL fl_after_done: got %0d, required 1", dones); end
  endtask

  task automatic test_flush_drain();
    int got, dones;
    load_vec(9, 0, IN);
    drain_vec(9, 10, 4'b1111, 1'b0, got, dones);
    out_ready = 1'b1; flush = 1'b1;
    #3;
    n_asrt++;
    if (done0 !== 1'b0) begin n_fail++; $display("FAIL fd_done: got %b, required 0", done0); end
    tick();
    flush = 1'b0; out_ready = 1'b0;
    n_asrt++;
    if ({out_valid0, in_ready0, busy0} !== 3'b000) begin
      n_fail++; $display("FAIL fd_idle: got %b, required 000", {out_valid0, in_ready0, busy0});
    end
    load_vec(11, 0, IN);
    drain_vec(11, OUT, 4'b1001, 1'b0, got, dones);
    n_asrt++;
    if (dones != 1) begin n_fail++; $display("FAIL fd_after_done: got %0d, required 1", dones); end
  endtask

  task automatic test_reset_mid();
    int got, dones;
    load_vec(2, 0, IN);
    drain_vec(2, 20, 4'b1111, 1'b0, got, dones);
    #2;
    rst_n = 1'b0;
    #1;
    n_asrt++;
    if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL rm_ctrl: valid/busy %b%b, required 00", out_valid0, busy0);
    end
    n_asrt++;
    if (x0[0] !== '0 || x0[IN-1] !== '0) begin
      n_fail++; $display("FAIL rm_xvec: got %0d/%0d, required 0/0", x0[0], x0[IN-1]);
    end
    #2;
    rst_n = 1'b1;
    tick();
    load_vec(4, 0, IN);
    drain_vec(4, OUT, 4'b1111, 1'b0, got, dones);
    n_asrt++;
    if (dones != 1) begin n_fail++; $display("FAIL rm_after_done: got %0d, required 1", dones); end
  endtask

  initial begin
    test_reset();
    test_settle_variants();
    test_backpressure();
    test_gaps();
    test_flush_load();
    test_flush_drain();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
